// File: rtl/ra_pkg.sv
// Shared types and defaults for the rolling-average window buffer.
package ra_pkg;

    typedef enum logic [1:0] {
        FILL,
        STEADY,
        DRAIN
    } ra_state_t;

    localparam int unsigned RA_BITS_PER_ELEM = 5;
    localparam int unsigned RA_NUM_ELEM      = 8;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ra_window_mem.sv
// Window sample storage: one synchronous write port, one asynchronous read port.
module ra_window_mem
    import ra_pkg::*;
#(
    parameter int unsigned BITS_PER_ELEM = RA_BITS_PER_ELEM,
    parameter int unsigned NUM_ELEM      = RA_NUM_ELEM,
    parameter int unsigned PW            = ptr_width(NUM_ELEM)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [PW-1:0]            wr_addr,
    input  logic [BITS_PER_ELEM-1:0] wr_data,
    input  logic [PW-1:0]            rd_addr,
    output logic [BITS_PER_ELEM-1:0] rd_data
);

    logic [BITS_PER_ELEM-1:0] mem [NUM_ELEM];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ra_window_buffer.sv
// Circular sample window feeding a rolling-average accumulator (new/old pairs, warm-up, drain).
// Optional RA_WINDOW_STATUS_EN exposes o_fill_level (registered sample count).
module ra_window_buffer
    import ra_pkg::*;
#(
    parameter int unsigned BITS_PER_ELEM = RA_BITS_PER_ELEM,
    parameter int unsigned NUM_ELEM      = RA_NUM_ELEM
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BITS_PER_ELEM-1:0] i_sample,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_clear,
    output logic [BITS_PER_ELEM-1:0] o_new,
    output logic [BITS_PER_ELEM-1:0] o_old,
    output logic                     o_start_calc
`ifdef RA_WINDOW_STATUS_EN
    ,
    output logic [$clog2(NUM_ELEM):0] o_fill_level
`endif
);

    localparam int unsigned PW = ptr_width(NUM_ELEM);
    localparam int unsigned CW = $clog2(NUM_ELEM) + 1;

    ra_state_t                state, state_n;
    logic [PW-1:0]            wr_ptr, wr_ptr_n;
    logic [CW-1:0]            count, count_n;
    logic [BITS_PER_ELEM-1:0] new_n, old_n;
    logic                     calc_n;
    logic                     wr_en;
    logic [PW-1:0]            oldest;
    logic [PW-1:0]            rd_addr;
    logic [BITS_PER_ELEM-1:0] rd_data;

    // A full window has count mod NUM_ELEM == 0, so oldest collapses to wr_ptr.
    assign oldest  = wr_ptr - count[PW-1:0];
    assign rd_addr = (state == DRAIN) ? oldest : wr_ptr;
    assign o_ready = (state != DRAIN) & ~i_clear & ~rst;

    ra_window_mem #(
        .BITS_PER_ELEM (BITS_PER_ELEM),
        .NUM_ELEM      (NUM_ELEM),
        .PW            (PW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (i_sample),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        count_n  = count;
        new_n    = o_new;
        old_n    = o_old;
        calc_n   = 1'b0;
        wr_en    = 1'b0;
        case (state)
            FILL, STEADY: begin
                if (i_clear) begin
                    if (count != '0) begin
                        state_n = DRAIN;
                    end
                end else if (i_valid) begin
                    wr_en    = 1'b1;
                    calc_n   = 1'b1;
                    new_n    = i_sample;
                    old_n    = (state == STEADY) ? rd_data : '0;
                    wr_ptr_n = wr_ptr + PW'(1);
                    if (state == FILL) begin
                        count_n = count + CW'(1);
                        if (count == CW'(NUM_ELEM - 1)) begin
                            state_n = STEADY;
                        end
                    end
                end
            end
            DRAIN: begin
                calc_n  = 1'b1;
                new_n   = '0;
                old_n   = rd_data;
                count_n = count - CW'(1);
                if (count == CW'(1)) begin
                    state_n = FILL;
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            wr_ptr       <= '0;
            count        <= '0;
            o_new        <= '0;
            o_old        <= '0;
            o_start_calc <= 1'b0;
        end else begin
            state        <= state_n;
            wr_ptr       <= wr_ptr_n;
            count        <= count_n;
            o_new        <= new_n;
            o_old        <= old_n;
            o_start_calc <= calc_n;
        end
    end

`ifdef RA_WINDOW_STATUS_EN
    assign o_fill_level = count;
`endif

endmodule

// File: doc/ra_window_buffer.md
# ra_window_buffer

Circular sample window that sits directly upstream of the rolling-average accumulator. Per accepted input sample it emits a registered pair: the new sample and the sample leaving the window, plus a one-cycle calculation strobe, so the accumulator can add new and subtract old. Tracks warm-up: evicted value is 0 until the window is full. Supports a controlled drain that subtracts every held sample back out, returning the downstream sum to 0 without a reset.

## Interface
- BITS_PER_ELEM, 5, sample width.
- NUM_ELEM, 8, window depth; power of two, ≥2.
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- i_sample  input  BITS_PER_ELEM  incoming sample.
- i_valid  input  1  i_sample valid this cycle.
- o_ready  output  1  sample accepted when i_valid & o_ready.
- i_clear  input  1  single-cycle request to drain the window.
- o_new  output  BITS_PER_ELEM  value to add; feeds accumulator i_new.
- o_old  output  BITS_PER_ELEM  value to subtract; feeds accumulator i_old.
- o_start_calc  output  1  one-cycle strobe qualifying o_new/o_old.
- o_fill_level  output  $clog2(NUM_ELEM)+1  samples held; present only with RA_WINDOW_STATUS_EN.

## Operation
- States: FILL (count < NUM_ELEM), STEADY (count == NUM_ELEM), DRAIN.
- Internal: wr_ptr (log2 NUM_ELEM bits, wraps NUM_ELEM-1→0), count (0..NUM_ELEM).
- Oldest entry index = (wr_ptr − count) mod NUM_ELEM.
- o_ready = (state != DRAIN) & ~i_clear & ~rst; combinational.
- Accept in FILL: mem[wr_ptr]←i_sample; o_new←i_sample; o_old←0; wr_ptr++; count++; count reaching NUM_ELEM → STEADY.
- Accept in STEADY: o_old←mem[wr_ptr] (pre-write read); mem[wr_ptr]←i_sample; o_new←i_sample; wr_ptr++; count unchanged.
- i_clear in FILL/STEADY: sample in same cycle not accepted; count==0 → stay FILL, no strobe; else → DRAIN.
- DRAIN, each cycle: o_new←0; o_old←mem[oldest]; strobe; count−−; count reaching 0 → FILL. Exactly count strobes, oldest-first. wr_ptr not changed. i_clear ignored in DRAIN.
- No accepted sample and not draining: o_start_calc←0; o_new/o_old hold.
- Sum of all (o_new − o_old) over strobes always equals sum of samples currently held; after a drain it is 0.

## Timing
- Reset values: o_new=0, o_old=0, o_start_calc=0, count=0, wr_ptr=0, state FILL; o_ready=0 during rst, 1 the cycle after.
- Memory contents not reset; never read before written (warm-up forces o_old=0).
- Latency: accept at edge N → o_new/o_old/o_start_calc valid after edge N, for one cycle of strobe.
- Back-to-back accepts: one strobe per cycle, no bubbles.
- Drain of k entries: k consecutive strobes starting the cycle after the i_clear edge; o_ready low those k cycles, high the cycle after last strobe.
- rst mid-drain or mid-fill: immediate return to reset values; remaining drain strobes abandoned (downstream also reset).

## Configuration
- RA_WINDOW_STATUS_EN defined: o_fill_level port present, equals registered count.
- Not defined: port absent; behaviour otherwise identical.

## Structure
- Shared package ra_pkg: state enum (FILL, STEADY, DRAIN), default BITS_PER_ELEM/NUM_ELEM constants, pointer-width helper.
- Sub-module ra_window_mem: NUM_ELEM×BITS_PER_ELEM storage, one synchronous write port, one asynchronous read port (read address = wr_ptr or oldest per state).

## Test plan
- NUM_ELEM=4, accept 3,5,7,9 back-to-back → strobes with (new,old) = (3,0),(5,0),(7,0),(9,0); state STEADY, count 4.
- Continue 11,13,31,2,0 → (11,3),(13,5),(31,7),(2,9),(0,11); wr_ptr wrap verified.
- Full window {13,31,2,0}, pulse i_clear → four strobes (0,13),(0,31),(0,2),(0,0); o_ready low 4 cycles; then FILL, count 0.
- i_clear with i_valid=1, i_sample=20, count=2 holding {4,6} → 20 not accepted; drain (0,4),(0,6); next sample 20 gives (20,0).
- i_clear with count 0 → no strobe, o_ready high next cycle; rst asserted after 1 of 3 drain strobes → outputs 0, FILL, o_ready=1 cycle after rst drops.
- Random samples 0..31, random clears, NUM_ELEM=8 → model accumulator of (o_new − o_old) equals sum of held samples every cycle, 0 after each drain.
